// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the ALU result stream and the buffered load/MC result
// stream onto the single register-file write port, preserving write-after-write order.
module wb_write_arbiter #(
   parameter int AWL   = 5,
   parameter int DWL   = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AWL-1:0]           alu_addr,
   input  logic [DWL-1:0]           alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [AWL-1:0]           lsu_addr,
   input  logic [DWL-1:0]           lsu_data,
   output logic                     wen,
   output logic [AWL-1:0]           WA,
   output logic [DWL-1:0]           WD,
   output logic [2**AWL-1:0]        pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] live_q;
   logic [AWL-1:0]   addr_q [DEPTH];
   logic [DWL-1:0]   data_q [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW:0]      count;

   logic empty;
   logic full;
   logic alu_wr;
   logic head_live;
   logic head_wr;
   logic pop;
   logic push;
   logic push_live;

   assign empty  = (count == '0);
   assign full   = (count == FULL_COUNT);
   assign alu_wr = alu_valid & (alu_addr != '0);

   // A head killed by this cycle's ALU write counts as dead already, so it drains now.
   assign head_live = ~empty & live_q[rptr] & ~(alu_wr & (addr_q[rptr] == alu_addr));
   assign head_wr   = head_live & ~alu_wr;
   assign pop       = ~empty & ~(alu_wr & head_live);

   assign lsu_ready = ~rst & ~full;
   assign push      = lsu_valid & lsu_ready & (lsu_addr != '0);
   assign push_live = ~(alu_wr & (alu_addr == lsu_addr));

   assign fifo_count = count;

   always_comb begin
      pending = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (live_q[i]) pending[addr_q[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_q <= '0;
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         wen    <= 1'b0;
         WA     <= '0;
         WD     <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_wr && (addr_q[i] == alu_addr)) live_q[i] <= 1'b0;
         end
         if (pop) begin
            live_q[rptr] <= 1'b0;
            rptr         <= rptr + PW'(1);
         end
         // Push slot never aliases the pop slot: push needs !full, pop needs !empty.
         if (push) begin
            live_q[wptr] <= push_live;
            wptr         <= wptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase

         if (alu_wr) begin
            wen <= 1'b1;
            WA  <= alu_addr;
            WD  <= alu_data;
         end else if (head_wr) begin
            wen <= 1'b1;
            WA  <= addr_q[rptr];
            WD  <= data_q[rptr];
         end else begin
            wen <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wptr] <= lsu_addr;
         data_q[wptr] <= lsu_data;
      end
   end

endmodule
